// File: rtl/uart_line_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_line_scheduler: round-robin arbiter printing "c:HHHH\r\n" per grant   |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module uart_line_scheduler #(
    parameter int NUMBER_OF_CHANNELS         = 4,
    parameter int LOG2_OF_NUMBER_OF_CHANNELS = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUMBER_OF_CHANNELS-1:0]         request,
    input  logic [16*NUMBER_OF_CHANNELS-1:0]      data,
    output logic [NUMBER_OF_CHANNELS-1:0]         grant_ack,
    input  logic                                  uart_busy,
    output logic                                  start_uart_transfer,
    output logic [7:0]                            byte_to_send,
    output logic                                  line_active,
    output logic [LOG2_OF_NUMBER_OF_CHANNELS-1:0] current_channel
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_GRANT       = 3'd1,
        S_SEND        = 3'd2,
        S_WAIT_ACCEPT = 3'd3,
        S_WAIT_DONE   = 3'd4
    } state_t;

    state_t                                  r_state;
    state_t                                  w_next_state;
    logic [LOG2_OF_NUMBER_OF_CHANNELS-1:0]   r_pointer;
    logic [LOG2_OF_NUMBER_OF_CHANNELS-1:0]   r_channel;
    logic [15:0]                             r_value;
    logic [2:0]                              r_index;
    logic [7:0]                              r_byte;
    logic [LOG2_OF_NUMBER_OF_CHANNELS-1:0]   w_pick;
    logic                                    w_pick_valid;

    function automatic logic [LOG2_OF_NUMBER_OF_CHANNELS-1:0] f_wrap(input int unsigned v);
        int unsigned m;
        m = v % NUMBER_OF_CHANNELS;
        return m[LOG2_OF_NUMBER_OF_CHANNELS-1:0];
    endfunction

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] f_char(input logic [2:0]                            idx,
                                          input logic [15:0]                           value,
                                          input logic [LOG2_OF_NUMBER_OF_CHANNELS-1:0] chan);
        logic [7:0] ch;
        case (idx)
            3'd0:    ch = 8'h30 + 8'(chan);
            3'd1:    ch = 8'h3A;
            3'd2:    ch = f_hex(value[15:12]);
            3'd3:    ch = f_hex(value[11:8]);
            3'd4:    ch = f_hex(value[7:4]);
            3'd5:    ch = f_hex(value[3:0]);
            3'd6:    ch = 8'h0D;
            default: ch = 8'h0A;
        endcase
        return ch;
    endfunction

    // Scan from the farthest offset back so the closest requester to the pointer wins.
    always_comb begin
        w_pick       = '0;
        w_pick_valid = 1'b0;
        for (int i = NUMBER_OF_CHANNELS - 1; i >= 0; i--) begin
            if (request[f_wrap(32'(r_pointer) + 32'(i))]) begin
                w_pick       = f_wrap(32'(r_pointer) + 32'(i));
                w_pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state        = r_state;
        start_uart_transfer = 1'b0;
        grant_ack           = '0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) w_next_state = S_GRANT;
            end
            S_GRANT: begin
                grant_ack[r_channel] = 1'b1;
                w_next_state         = S_SEND;
            end
            S_SEND: begin
                // Hold off the strobe if the transmitter is still finishing earlier work.
                if (!uart_busy) begin
                    start_uart_transfer = 1'b1;
                    w_next_state        = S_WAIT_ACCEPT;
                end
            end
            S_WAIT_ACCEPT: begin
                if (uart_busy) w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!uart_busy) w_next_state = (r_index == 3'd7) ? S_IDLE : S_SEND;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pointer <= '0;
            r_channel <= '0;
            r_value   <= '0;
            r_index   <= '0;
            r_byte    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) r_channel <= w_pick;
                end
                S_GRANT: begin
                    r_value   <= data[16*r_channel +: 16];
                    r_index   <= 3'd0;
                    r_pointer <= f_wrap(32'(r_channel) + 32'd1);
                    r_byte    <= f_char(3'd0, 16'h0000, r_channel);
                end
                S_WAIT_DONE: begin
                    // The next byte is registered on entry to SEND and held until the following SEND.
                    if (!uart_busy && r_index != 3'd7) begin
                        r_index <= r_index + 3'd1;
                        r_byte  <= f_char(r_index + 3'd1, r_value, r_channel);
                    end
                end
                default: ;
            endcase
        end
    end

    assign line_active     = (r_state != S_IDLE);
    assign byte_to_send    = r_byte;
    assign current_channel = r_channel;

endmodule
`default_nettype wire
